// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - ADXL345 register constants and poller state encoding
package accel_pkg;

    localparam logic [7:0] REG_DATA_FORMAT = 8'h31;
    localparam logic [7:0] REG_POWER_CTL   = 8'h2D;
    localparam logic [7:0] REG_DATAX0      = 8'h32;
    localparam logic [7:0] PWR_MEASURE     = 8'h08;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        INIT_ISSUE = 4'd1,
        INIT_WAIT  = 4'd2,
        POLL_WAIT  = 4'd3,
        RD_ISSUE   = 4'd4,
        RD_WAIT    = 4'd5,
        PUBLISH    = 4'd6,
        ERROR      = 4'd7
    } accel_poll_state_e;

endpackage

// File: rtl/period_tick.sv
// rtl/period_tick.sv - free-running down-counter emitting a 1-cycle tick every PERIOD cycles
module period_tick #(
    parameter int unsigned PERIOD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LOAD = W'(PERIOD - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= LOAD;
        end else if (clear || cnt == '0) begin
            cnt <= LOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

    // clear holds the phase at zero so the first tick lands PERIOD cycles after release
    assign tick = !clear && (cnt == '0);

endmodule

// File: rtl/accel_poller.sv
// rtl/accel_poller.sv - ADXL345 init and fixed-rate XYZ poller driving an i2c_controller
module accel_poller
    import accel_pkg::*;
#(
    parameter int unsigned SYS_CLK_SPEED   = 50_000_000,
    parameter int unsigned SAMPLE_RATE_HZ  = 100,
    parameter logic [6:0]  DEV_ADDR        = 7'h1D,
    parameter logic [7:0]  DATA_FORMAT_VAL = 8'h0B,
    parameter int unsigned TIMEOUT_CYCLES  = 100_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic [6:0]  i2c_dev_addr,
    output logic [7:0]  i2c_reg_addr,
    output logic        i2c_r_w,
    output logic [7:0]  i2c_write_data,
    output logic        i2c_start,
    input  logic        i2c_ready,
    input  logic        i2c_finished,
    input  logic [7:0]  i2c_read_data,
    output logic [15:0] accel_x,
    output logic [15:0] accel_y,
    output logic [15:0] accel_z,
    output logic        sample_valid,
    output logic        init_done,
    output logic        error,
    output logic [3:0]  dbg_state
);

    localparam int unsigned PERIOD = SYS_CLK_SPEED / SAMPLE_RATE_HZ;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    accel_poll_state_e state;
    logic [2:0]        idx;
    logic              init_step;
    logic [TW-1:0]     tmo_cnt;
    logic              pending;
    logic [5:0][7:0]   shadow;
    logic              tick;
    logic              timer_clear;

    // The sample period only runs while polling; it restarts on each entry from IDLE/init.
    assign timer_clear = !(state inside {POLL_WAIT, RD_ISSUE, RD_WAIT, PUBLISH});

    period_tick #(.PERIOD(PERIOD)) u_period (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .tick  (tick)
    );

    assign i2c_dev_addr = DEV_ADDR;
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            idx            <= '0;
            init_step      <= 1'b0;
            tmo_cnt        <= '0;
            pending        <= 1'b0;
            shadow         <= '0;
            i2c_reg_addr   <= '0;
            i2c_r_w        <= 1'b1;
            i2c_write_data <= '0;
            i2c_start      <= 1'b0;
            accel_x        <= '0;
            accel_y        <= '0;
            accel_z        <= '0;
            sample_valid   <= 1'b0;
            init_done      <= 1'b0;
            error          <= 1'b0;
        end else begin
            i2c_start    <= 1'b0;
            sample_valid <= 1'b0;
            // Ticks that land during a long read set are remembered, not lost.
            if (timer_clear)
                pending <= 1'b0;
            else if (tick)
                pending <= 1'b1;

            case (state)
                IDLE: begin
                    init_step <= 1'b0;
                    if (enable)
                        state <= init_done ? POLL_WAIT : INIT_ISSUE;
                end
                INIT_ISSUE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (i2c_ready) begin
                        i2c_start      <= 1'b1;
                        i2c_r_w        <= 1'b0;
                        i2c_reg_addr   <= init_step ? REG_POWER_CTL : REG_DATA_FORMAT;
                        i2c_write_data <= init_step ? PWR_MEASURE : DATA_FORMAT_VAL;
                        tmo_cnt        <= '0;
                        state          <= INIT_WAIT;
                    end
                end
                INIT_WAIT: begin
                    if (i2c_finished) begin
                        if (init_step) begin
                            init_done <= 1'b1;
                            state     <= enable ? POLL_WAIT : IDLE;
                        end else begin
                            init_step <= 1'b1;
                            state     <= enable ? INIT_ISSUE : IDLE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                POLL_WAIT: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (pending || tick) begin
                        pending <= 1'b0;
                        idx     <= '0;
                        state   <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (i2c_ready) begin
                        i2c_start    <= 1'b1;
                        i2c_r_w      <= 1'b1;
                        i2c_reg_addr <= REG_DATAX0 + {5'd0, idx};
                        tmo_cnt      <= '0;
                        state        <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (i2c_finished) begin
                        shadow[idx] <= i2c_read_data;
                        if (!enable) begin
                            state <= IDLE;
                        end else if (idx == 3'd5) begin
                            state <= PUBLISH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= RD_ISSUE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= ERROR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                PUBLISH: begin
                    accel_x      <= {shadow[1], shadow[0]};
                    accel_y      <= {shadow[3], shadow[2]};
                    accel_z      <= {shadow[5], shadow[4]};
                    sample_valid <= 1'b1;
                    state        <= POLL_WAIT;
                end
                ERROR: begin
                    state <= ERROR;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_poller.sv
// tb/tb_accel_poller.sv - directed self-checking bench for accel_poller with a behavioural i2c model
module tb_accel_poller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [6:0]  i2c_dev_addr;
    logic [7:0]  i2c_reg_addr;
    logic        i2c_r_w;
    logic [7:0]  i2c_write_data;
    logic        i2c_start;
    logic        i2c_ready;
    logic        i2c_finished;
    logic [7:0]  i2c_read_data;
    logic [15:0] accel_x, accel_y, accel_z;
    logic        sample_valid, init_done, error;
    logic [3:0]  dbg_state;

    always #5 clk = ~clk;

    accel_poller #(
        .SYS_CLK_SPEED  (200_000),
        .SAMPLE_RATE_HZ (100),
        .TIMEOUT_CYCLES (1000)
    ) dut (
        .clk            (clk),
        .rst            (rst_n),
        .enable         (enable),
        .i2c_dev_addr   (i2c_dev_addr),
        .i2c_reg_addr   (i2c_reg_addr),
        .i2c_r_w        (i2c_r_w),
        .i2c_write_data (i2c_write_data),
        .i2c_start      (i2c_start),
        .i2c_ready      (i2c_ready),
        .i2c_finished   (i2c_finished),
        .i2c_read_data  (i2c_read_data),
        .accel_x        (accel_x),
        .accel_y        (accel_y),
        .accel_z        (accel_z),
        .sample_valid   (sample_valid),
        .init_done      (init_done),
        .error          (error),
        .dbg_state      (dbg_state)
    );

    logic [7:0] mem [64];
    int         latency;
    bit         hang;
    bit         busy;
    int         mcnt;
    logic [7:0] maddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2c_ready     <= 1'b1;
            i2c_finished  <= 1'b0;
            i2c_read_data <= 8'h00;
            busy          <= 1'b0;
            mcnt          <= 0;
            maddr         <= 8'h00;
        end else begin
            i2c_finished <= 1'b0;
            if (!busy && i2c_start && i2c_ready) begin
                busy      <= 1'b1;
                i2c_ready <= 1'b0;
                mcnt      <= latency;
                maddr     <= i2c_reg_addr;
            end else if (busy && !hang) begin
                if (mcnt == 1) begin
                    i2c_finished  <= 1'b1;
                    i2c_ready     <= 1'b1;
                    i2c_read_data <= mem[maddr[5:0]];
                    busy          <= 1'b0;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end
    end

    int         cyc = 0;
    logic [7:0] st_addr [$];
    logic       st_rw   [$];
    logic [7:0] st_wd   [$];
    int         sv_cyc  [$];
    int         init_fin_q [$];
    int         n_starts = 0;
    int         n_fin = 0;
    int         bad_start = 0;
    int         last_start_cyc = 0;
    int         err_cyc = 0;
    logic       prev_init = 1'b0;
    logic       prev_err = 1'b0;

    always @(posedge clk) begin
        if (rst_n) begin
            if (i2c_start) begin
                st_addr.push_back(i2c_reg_addr);
                st_rw.push_back(i2c_r_w);
                st_wd.push_back(i2c_write_data);
                n_starts++;
                last_start_cyc = cyc;
                if (!i2c_ready) bad_start++;
            end
            if (i2c_finished) n_fin++;
            if (sample_valid) sv_cyc.push_back(cyc);
            if (init_done && !prev_init) init_fin_q.push_back(n_fin);
            if (error && !prev_err) err_cyc = cyc;
        end
        prev_init = init_done;
        prev_err  = error;
        cyc++;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_sv(input int bound, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (sample_valid) begin ok = 1'b1; break; end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_starts(input int target, input int bound, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (n_starts >= target) begin ok = 1'b1; break; end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_init(input int bound, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (init_done) begin ok = 1'b1; break; end
        end
        chk(tag, {31'd0, ok}, 32'd1);
    endtask

    initial begin
        int base;
        int fin0;
        bit ok;

        rst_n   = 1'b0;
        enable  = 1'b0;
        latency = 50;
        hang    = 1'b0;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        mem[50] = 8'h01; mem[51] = 8'hFF; mem[52] = 8'h00;
        mem[53] = 8'h80; mem[54] = 8'h34; mem[55] = 8'h12;

        repeat (3) @(negedge clk);
        chk("rst_x", 32'(accel_x), 32'h0);
        chk("rst_y", 32'(accel_y), 32'h0);
        chk("rst_z", 32'(accel_z), 32'h0);
        chk("rst_sv", 32'(sample_valid), 32'h0);
        chk("rst_init_done", 32'(init_done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_start", 32'(i2c_start), 32'h0);
        chk("rst_dev_addr", 32'(i2c_dev_addr), 32'h1D);
        chk("rst_r_w", 32'(i2c_r_w), 32'h1);
        chk("rst_state", 32'(dbg_state), 32'h0);

        // init writes
        rst_n  = 1'b1;
        enable = 1'b1;
        wait_init(1000, "init_wait");
        @(negedge clk);
        chk("init_starts", n_starts, 2);
        chk("init0_addr", 32'(st_addr[0]), 32'h31);
        chk("init0_rw", 32'(st_rw[0]), 32'h0);
        chk("init0_wd", 32'(st_wd[0]), 32'h0B);
        chk("init1_addr", 32'(st_addr[1]), 32'h2D);
        chk("init1_rw", 32'(st_rw[1]), 32'h0);
        chk("init1_wd", 32'(st_wd[1]), 32'h08);
        chk("init_after_2nd_fin", (init_fin_q.size() > 0) ? init_fin_q[0] : -1, 2);

        // first sample set
        wait_sv(5000, "sv1_wait");
        chk("sv1_x", 32'(accel_x), 32'hFF01);
        chk("sv1_y", 32'(accel_y), 32'h8000);
        chk("sv1_z", 32'(accel_z), 32'h1234);
        chk("sv1_starts", n_starts, 8);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("rd%0d_addr", i), 32'(st_addr[2+i]), 32'h32 + i);
            chk($sformatf("rd%0d_rw", i), 32'(st_rw[2+i]), 32'h1);
        end
        latency = 10;

        // period spacing, short transactions
        for (int k = 0; k < 5; k++) wait_sv(2500, "fast_sv_wait");
        @(negedge clk);
        latency = 500;
        for (int k = 1; k < 5; k++)
            chk($sformatf("fast_spacing%0d", k), sv_cyc[k+1] - sv_cyc[k], 2000);

        // long transactions: sets run back to back, 6 x (500 + 3) + 2
        for (int k = 0; k < 4; k++) wait_sv(6000, "slow_sv_wait");
        latency = 10;
        mem[50] = 8'hAA; mem[51] = 8'hBB; mem[52] = 8'hCC;
        base = n_starts;
        @(negedge clk);
        for (int k = 6; k < 9; k++)
            chk($sformatf("slow_spacing%0d", k), sv_cyc[k+1] - sv_cyc[k], 3020);

        // drop enable during the 3rd byte of a set
        wait_starts(base + 3, 3000, "drop_wait");
        enable = 1'b0;
        repeat (200) @(negedge clk);
        chk("drop_starts", n_starts, base + 3);
        chk("drop_sv_count", sv_cyc.size(), 10);
        chk("drop_hold_x", 32'(accel_x), 32'hFF01);
        chk("drop_hold_y", 32'(accel_y), 32'h8000);
        chk("drop_hold_z", 32'(accel_z), 32'h1234);
        chk("drop_state_idle", 32'(dbg_state), 32'h0);

        // async reset in the middle of a read
        latency = 200;
        enable  = 1'b1;
        base = n_starts;
        wait_starts(base + 4, 3000, "rstmid_wait");
        repeat (50) @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rstmid_x", 32'(accel_x), 32'h0);
        chk("rstmid_y", 32'(accel_y), 32'h0);
        chk("rstmid_z", 32'(accel_z), 32'h0);
        chk("rstmid_init_done", 32'(init_done), 32'h0);
        chk("rstmid_state", 32'(dbg_state), 32'h0);
        chk("rstmid_r_w", 32'(i2c_r_w), 32'h1);
        chk("rstmid_start", 32'(i2c_start), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        base = n_starts;
        wait_init(2000, "reinit_wait");
        chk("reinit0_addr", 32'(st_addr[base]), 32'h31);
        chk("reinit0_wd", 32'(st_wd[base]), 32'h0B);
        chk("reinit1_addr", 32'(st_addr[base+1]), 32'h2D);

        // finished in the timeout-expiry cycle wins, then a hung transaction times out
        latency = 998;
        fin0 = n_fin;
        base = n_starts;
        wait_starts(base + 1, 3000, "tmo_start_wait");
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (n_fin > fin0) begin ok = 1'b1; break; end
        end
        chk("edge_fin_wait", {31'd0, ok}, 32'd1);
        hang = 1'b1;
        chk("fin_beats_timeout", 32'(error), 32'h0);
        ok = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (error) begin ok = 1'b1; break; end
        end
        chk("tmo_error_wait", {31'd0, ok}, 32'd1);
        @(negedge clk);
        chk("tmo_latency", err_cyc - last_start_cyc, 1000);
        base = n_starts;
        repeat (300) @(negedge clk);
        chk("tmo_no_more_starts", n_starts, base);
        chk("tmo_state_error", 32'(dbg_state), 32'h7);
        chk("tmo_error_sticky", 32'(error), 32'h1);
        chk("start_only_when_ready", bad_start, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
